regfile_dump_streamer: RTL and testbench

Debug reader for the 32-entry CPU register file: on a start request it walks every architectural register through a spare combinational read port and streams each value out on a valid/ready interface for a debug or trace host. It sits beside the register file in the core, driving a dedicated read address and consuming the read data. It never writes the register file.

---
 rtl/regfile_dump_streamer.sv | 82 ++++++++
 tb/tb_regfile_dump_streamer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/regfile_dump_streamer.sv
// regfile_dump_streamer: walks the register file over valid/ready; REGDUMP_CHECKSUM_EN appends an XOR checksum word
module regfile_dump_streamer #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last
);
  typedef enum logic [2:0] {
    IDLE, FETCH, SEND,
`ifdef REGDUMP_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;
  state_t state, next;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data_q;
  logic last_reg;
  assign last_reg = idx == ADDR_W'(NUM_REGS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = start ? FETCH : IDLE;
      FETCH: next = SEND;
`ifdef REGDUMP_CHECKSUM_EN
      SEND:  next = !m_ready ? SEND : last_reg ? CSUM : FETCH;
      CSUM:  next = m_ready ? DONE : CSUM;
`else
      SEND:  next = !m_ready ? SEND : last_reg ? DONE : FETCH;
`endif
      default: next = IDLE;
    endcase
    if (abort && state != IDLE) next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx    <= '0;
      data_q <= '0;
    end else begin
      idx    <= next == IDLE ? '0 : (state == SEND && m_ready && !last_reg) ? idx + 1'b1 : idx;
      data_q <= state == FETCH ? rd_data : data_q;
    end
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum <= '0;
    else if ((state == IDLE && start) || abort) csum <= '0;
    else if (state == SEND && m_ready) csum <= csum ^ data_q;
`endif
  always_comb begin
    busy    = state != IDLE;
    done    = state == DONE;
    rd_addr = idx;
`ifdef REGDUMP_CHECKSUM_EN
    m_valid = state == SEND || state == CSUM;
    m_data  = state == CSUM ? csum : data_q;
    m_index = state == CSUM ? '0 : idx;
    m_last  = state == CSUM;
`else
    m_valid = state == SEND;
    m_data  = data_q;
    m_index = idx;
    m_last  = state == SEND && last_reg;
`endif
  end
endmodule

// File: tb/tb_regfile_dump_streamer.sv
// tb_regfile_dump_streamer: randomized directed bench with a word-list reference model
module tb_regfile_dump_streamer;
  localparam int N = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic clk = 0;
  logic rst_n, start, abort, busy, done, m_valid, m_ready, m_last;
  logic [4:0] rd_addr, m_index;
  logic [31:0] rd_data, m_data;
  logic [31:0] rf [N];
  int tests = 0, fails = 0;
  typedef struct {int idx; logic [31:0] data; bit last;} word_t;
  word_t exp_q[$];
  always #5 clk = ~clk;
  assign rd_data = rf[rd_addr];
  regfile_dump_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .m_last(m_last)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_index"}, m_index, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
  endtask
  // Expected stream: every register in order, then the XOR of all of them when the checksum is built in
  task automatic build();
    logic [31:0] x = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back('{i, rf[i], CS == 0 && i == N - 1});
      x ^= rf[i];
    end
    if (CS != 0) exp_q.push_back('{0, x, 1'b1});
  endtask
  task automatic run(input bit rnd, input int stall_idx, input int abort_idx, input int rst_idx,
                     input bit noise, input bit hold);
    bit held = 0;
    int stall_left = 5;
    logic [31:0] hd = 0;
    logic [4:0] hi = 0;
    word_t w;
    build();
    start = 1; abort = 0; m_ready = 1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      start = hold ? 1'b1 : noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (held) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hd);
        chk("hold_index", m_index, hi);
      end
      if (busy && !m_valid && !done && exp_q.size() > 0) chk("rd_addr", rd_addr, exp_q[0].idx);
      if (done) begin
        chk("done_pending", exp_q.size(), 0);
        if (!rnd && stall_idx < 0) chk("done_cycle", cyc, 2 * N + 1 + CS);
        start = hold;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        return;
      end
      if (m_valid && m_index == rst_idx) begin
        start = 0;
        #2 rst_n = 0;
        #1 chk_reset("midrst");
        @(negedge clk);
        rst_n = 1;
        return;
      end
      if (m_valid && m_index == abort_idx) begin
        abort = 1; start = 1;
        @(negedge clk);
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        abort = 0; start = 0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        return;
      end
      if (m_valid && m_index == stall_idx && !m_last && stall_left > 0) begin
        m_ready = 0;
        stall_left--;
      end else m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("word_index", m_index, w.idx);
          chk("word_data", m_data, w.data);
          chk("word_last", m_last, w.last);
        end
      end
      held = m_valid && !m_ready;
      hd = m_data;
      hi = m_index;
    end
    chk("timeout", 0, 1);
  endtask
  initial begin
    rst_n = 0; start = 0; abort = 0; m_ready = 0;
    for (int i = 0; i < N; i++) rf[i] = i == 0 ? 32'h0 : 32'h1000_0000 + i;
    @(negedge clk);
    chk_reset("reset");
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    run(0, -1, -1, -1, 0, 0);
    for (int i = 1; i < N; i++) rf[i] = $urandom;
    run(1, 7, -1, -1, 1, 0);
    run(0, -1, 12, -1, 0, 0);
    run(0, -1, -1, -1, 0, 0);
    run(1, -1, -1, 20, 0, 0);
    chk("post_midrst_busy", busy, 0);
    run(0, -1, -1, -1, 0, 1);
    @(negedge clk);
    chk("hold_restart", busy, 1);
    abort = 1; start = 0;
    @(negedge clk);
    chk("hold_abort", busy, 0);
    abort = 0;
    for (int i = 1; i < N; i++) rf[i] = $urandom;
    run(1, -1, -1, -1, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
